osc_model_fixed: RTL and testbench
==================================

# osc_model_fixed

Fixed-point emulated oscillator. It consumes per-phase low/high durations (`t_lo`, `t_hi`, in `DT_SCALE` units) and requests the time remaining until its next edge on `dt_req`. From the globally granted timestep `emu_dt` it advances its phase and produces the emulated clock level plus a one-cycle rising-edge enable. It sits between the simulation-control block that drives `t_lo`/`t_hi` and the time manager that computes `emu_dt` as the minimum over all `dt_req`.

## Interface
Parameters:
- `DT_WIDTH`, 32, width of all time quantities (unsigned, LSB = `DT_SCALE` seconds)
- `INIT_HI`, 0, emulated clock level after reset

Ports:
- `emu_clk`  in  1  emulator clock
- `emu_rst`  in  1  reset; **one clock; reset is asynchronous and active-high**
- `t_lo`  in  DT_WIDTH  low-phase duration
- `t_hi`  in  DT_WIDTH  high-phase duration
- `emu_dt`  in  DT_WIDTH  timestep granted this cycle
- `dt_req`  out  DT_WIDTH  requested timestep = time remaining in current phase
- `clk_val`  out  1  emulated clock level
- `cke`  out  1  rising-edge enable for downstream emulated-clock logic
- `edge_cnt`  out  32  count of rising edges
- `err`  out  1  sticky overshoot flag

## Operation
- States: `LOAD`, `RUN`.
- Reset values: state `LOAD`, `rem`=0, `clk_val`=`INIT_HI`, `edge_cnt`=0, `err`=0.
- `dt_req` in `LOAD` = all-ones, so the oscillator places no constraint on the time manager.
- `LOAD` lasts exactly one cycle:
  - `rem` ← phase duration for `clk_val` (`t_hi` if high, else `t_lo`).
  - Next state is `RUN`.
- `dt_req` in `RUN` = `rem`.
- `RUN`, per cycle:
  - `emu_dt`==0: hold all state.
  - 0<`emu_dt`<`rem`: `rem` ← `rem`−`emu_dt`; no edge.
  - `emu_dt`==`rem`: edge.
    - `clk_val` toggles.
    - `rem` ← duration of the new phase, sampled from `t_lo`/`t_hi` in this cycle.
    - If the edge is rising, `edge_cnt` increments; it wraps at 2^32 with no flag.
  - `emu_dt`>`rem`: behaviour is set by the configuration macro.
- Zero duration: a phase duration of 0 is loaded as 1, so `dt_req` is never 0 in `RUN` and the time manager cannot deadlock.
- `t_lo`/`t_hi` changes mid-phase do not alter `rem`. They take effect only at the next phase load.
- `emu_rst` asserted mid-phase returns the block to reset values immediately, independent of `emu_clk`.

## Timing
- `dt_req`, `clk_val`, `edge_cnt` and `err` are registered. They update on the `emu_clk` edge that samples the triggering `emu_dt`.
- `cke` is combinational: `cke` = (state==`RUN`) & ~`clk_val` & (`emu_dt`==`rem`).
  - It is high in the cycle before `clk_val` rises.
  - Logic gated by `cke` therefore updates on the same `emu_clk` edge as the emulated rising edge.
- After reset deassertion: one `LOAD` cycle, then the first valid `dt_req` is visible.
- Throughput: at most one emulated edge per `emu_clk` cycle.

## Configuration
- `OSC_MODEL_ERR_CHECK_EN` defined:
  - `emu_dt`>`rem` sets `err`, which stays 1 until reset.
  - State freezes: no edge, `rem` unchanged, `cke`=0.
- Not defined:
  - `err` is tied to 0.
  - `emu_dt`>`rem` is treated as `emu_dt`==`rem` (edge taken, overshoot discarded), and `cke` uses `emu_dt`>=`rem`.

## Structure
- Package `osc_model_pkg` holds:
  - the `DT_WIDTH` default;
  - `localparam DT_MAX` (all-ones);
  - `typedef enum logic {LOAD, RUN} osc_state_t`;
  - a function returning max(duration, 1).
- No sub-module; single module of roughly 150 lines.

## Test plan
- **Exact stepping:** `t_lo`=3, `t_hi`=5, `INIT_HI`=0, `emu_dt`=`dt_req` each cycle. Required: `dt_req` sequence `DT_MAX`,3,5,3,5; `clk_val` toggles every cycle; `cke` high on every low→high step; `edge_cnt`=2 after 4 edges.
- **Partial steps:** `t_lo`=3, `emu_dt`=1. Required: `dt_req` 3,2,1; `clk_val` rises on the third step; `cke` high only in that cycle.
- **Zero-duration phase:** `t_hi`=0. Required: `dt_req`=1 during the high phase, never 0.
- **Mid-phase change:** change `t_lo` from 3 to 7 with `rem`=2. Required: the current phase ends after 2; the next low phase requests 7.
- **Overshoot:** `emu_dt`=4 with `rem`=3. With the macro: `err`=1, `clk_val` unchanged, `dt_req` stays 3. Without the macro: edge taken, `err`=0.
- **Reset mid-phase:** assert `emu_rst` with `rem`=2 and `edge_cnt`=5. Required: all outputs return to reset values asynchronously; one `LOAD` cycle follows deassertion.

Source files
------------

// File: rtl/osc_model_pkg.sv
// rtl/osc_model_pkg.sv - shared types, constants and helpers for the emulated oscillator
//
// Purpose: holds the default time-quantity width, the all-ones "no constraint"
// timestep value, the two-state controller enum and the zero-duration clamp.
// No ports (package).

package osc_model_pkg;

  localparam int DT_WIDTH_DEF = 32;

  // All-ones timestep: a requester that places no constraint on the time manager.
  localparam logic [DT_WIDTH_DEF-1:0] DT_MAX = {DT_WIDTH_DEF{1'b1}};

  typedef enum logic {LOAD, RUN} osc_state_t;

  // A zero-length phase would make the oscillator request dt=0 forever and
  // stall every other model, so durations are clamped to at least one unit.
  // Operates on 64 bits so any DT_WIDTH up to 64 can share it.
  function automatic logic [63:0] dur_min1(input logic [63:0] dur);
    return (dur == 64'd0) ? 64'd1 : dur;
  endfunction

endpackage

// File: rtl/osc_model_fixed.sv
// rtl/osc_model_fixed.sv - fixed-point emulated oscillator driven by a granted timestep
//
// Purpose: tracks the time remaining in the current low/high phase, asks the
// time manager for exactly that much time, and toggles the emulated clock when
// the granted step consumes the phase.
// Configuration macro: OSC_MODEL_ERR_CHECK_EN (overshoot detection, sticky err).
//
// Ports:
//   emu_clk   in   emulator clock
//   emu_rst   in   asynchronous active-high reset
//   t_lo      in   low-phase duration  (DT_WIDTH)
//   t_hi      in   high-phase duration (DT_WIDTH)
//   emu_dt    in   timestep granted this cycle (DT_WIDTH)
//   dt_req    out  time remaining in the current phase, all-ones while loading
//   clk_val   out  emulated clock level
//   cke       out  combinational rising-edge enable (high the cycle before clk_val rises)
//   edge_cnt  out  count of rising edges, wraps silently
//   err       out  sticky overshoot flag (tied low without OSC_MODEL_ERR_CHECK_EN)

module osc_model_fixed
  import osc_model_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF,
  parameter bit INIT_HI  = 1'b0
) (
  input  logic                emu_clk,
  input  logic                emu_rst,
  input  logic [DT_WIDTH-1:0] t_lo,
  input  logic [DT_WIDTH-1:0] t_hi,
  input  logic [DT_WIDTH-1:0] emu_dt,
  output logic [DT_WIDTH-1:0] dt_req,
  output logic                clk_val,
  output logic                cke,
  output logic [31:0]         edge_cnt,
  output logic                err
);

  osc_state_t          state;
  logic [DT_WIDTH-1:0] rem;
  logic [DT_WIDTH-1:0] load_dur;
  logic [DT_WIDTH-1:0] next_dur;
  logic                hit;
  logic                over;
  logic                take_edge;

  assign hit  = (emu_dt == rem);
  assign over = (emu_dt > rem);

  // Duration of the phase we are entering: on LOAD it is the current level's
  // phase, on an edge it is the opposite level's phase.
  assign load_dur = DT_WIDTH'(dur_min1(64'(clk_val ? t_hi : t_lo)));
  assign next_dur = DT_WIDTH'(dur_min1(64'(clk_val ? t_lo : t_hi)));

`ifdef OSC_MODEL_ERR_CHECK_EN
  // Overshoot is an error: freeze instead of taking the edge.
  assign take_edge = hit;
`else
  // Overshoot is absorbed: the excess time is simply discarded.
  assign take_edge = hit | over;
`endif

  assign cke    = (state == RUN) & ~clk_val & take_edge;
  assign dt_req = (state == LOAD) ? {DT_WIDTH{1'b1}} : rem;

`ifdef OSC_MODEL_ERR_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state    <= LOAD;
      rem      <= '0;
      clk_val  <= INIT_HI;
      edge_cnt <= '0;
`ifdef OSC_MODEL_ERR_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else if (state == LOAD) begin
      rem   <= load_dur;
      state <= RUN;
    end else begin
      if (take_edge) begin
        clk_val <= ~clk_val;
        rem     <= next_dur;
        if (!clk_val) begin
          edge_cnt <= edge_cnt + 32'd1;
        end
`ifdef OSC_MODEL_ERR_CHECK_EN
      end else if (over) begin
        err_q <= 1'b1;
`endif
      end else begin
        // rem is never 0 in RUN, so emu_dt==0 lands here and holds rem.
        rem <= rem - emu_dt;
      end
    end
  end

endmodule

// File: tb/tb_osc_model_fixed.sv
// tb/tb_osc_model_fixed.sv - self-checking bench for osc_model_fixed

module tb_osc_model_fixed;
  import osc_model_pkg::*;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

`ifdef OSC_MODEL_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        emu_clk;
  logic        emu_rst;
  logic [31:0] t_lo;
  logic [31:0] t_hi;
  logic [31:0] emu_dt;
  logic [31:0] dt_req;
  logic        clk_val;
  logic        cke;
  logic [31:0] edge_cnt;
  logic        err;

  int n_chk;
  int n_fail;

  osc_model_fixed #(.DT_WIDTH(32), .INIT_HI(1'b0)) dut (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .t_lo    (t_lo),
    .t_hi    (t_hi),
    .emu_dt  (emu_dt),
    .dt_req  (dt_req),
    .clk_val (clk_val),
    .cke     (cke),
    .edge_cnt(edge_cnt),
    .err     (err)
  );

  initial begin
    emu_clk = 1'b0;
    forever #5 emu_clk = ~emu_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after a posedge, combinational outputs sampled 1ns later.
  task automatic apply(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] dt);
    t_lo   = lo;
    t_hi   = hi;
    emu_dt = dt;
    #1;
  endtask

  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  // Reference model: phase bookkeeping as "elapsed time within a phase of known length".
  bit          m_loaded;
  bit          m_level;
  logic [31:0] m_dur;
  logic [31:0] m_elapsed;
  logic [31:0] m_edges;
  bit          m_err;

  function automatic logic [31:0] clamp1(input logic [31:0] d);
    return (d == 0) ? 32'd1 : d;
  endfunction

  function automatic logic [31:0] m_remaining();
    return m_dur - m_elapsed;
  endfunction

  function automatic logic [31:0] m_dt_req();
    return m_loaded ? m_remaining() : ALL1;
  endfunction

  function automatic bit m_cke(input logic [31:0] dt);
    if (!m_loaded || m_level) return 1'b0;
    return ERR_EN ? (dt == m_remaining()) : (dt >= m_remaining());
  endfunction

  task automatic m_reset();
    m_loaded = 0; m_level = 0; m_dur = 0; m_elapsed = 0; m_edges = 0; m_err = 0;
  endtask

  task automatic m_step(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] dt);
    logic [31:0] r;
    if (!m_loaded) begin
      m_dur     = clamp1(m_level ? hi : lo);
      m_elapsed = 0;
      m_loaded  = 1;
    end else begin
      r = m_remaining();
      if (dt < r) begin
        m_elapsed = m_elapsed + dt;
      end else if (ERR_EN && dt > r) begin
        m_err = 1;
      end else begin
        if (!m_level) m_edges = m_edges + 1;
        m_level   = !m_level;
        m_dur     = clamp1(m_level ? hi : lo);
        m_elapsed = 0;
      end
    end
  endtask

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] dt;
    bit          e_cke;
    logic [31:0] e_dt_req;
    bit          e_clk;
    logic [31:0] e_edges;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] r, dt, lo, hi;
    int sel;

    n_chk = 0;
    n_fail = 0;

    // lo  hi  dt   cke  dt_req clk edges   (dt_req/clk/edges after the edge)
    vecs[0]  = '{3, 5, 0, 0, 3, 0, 0};   // LOAD
    vecs[1]  = '{3, 5, 3, 1, 5, 1, 1};   // exact stepping
    vecs[2]  = '{3, 5, 5, 0, 3, 0, 1};
    vecs[3]  = '{3, 5, 3, 1, 5, 1, 2};
    vecs[4]  = '{3, 5, 5, 0, 3, 0, 2};
    vecs[5]  = '{3, 5, 1, 0, 2, 0, 2};   // partial steps
    vecs[6]  = '{3, 5, 1, 0, 1, 0, 2};
    vecs[7]  = '{3, 5, 1, 1, 5, 1, 3};
    vecs[8]  = '{3, 0, 5, 0, 3, 0, 3};   // zero-duration high phase
    vecs[9]  = '{3, 0, 3, 1, 1, 1, 4};
    vecs[10] = '{3, 0, 0, 0, 1, 1, 4};   // dt=0 holds
    vecs[11] = '{3, 0, 1, 0, 3, 0, 4};
    vecs[12] = '{3, 5, 1, 0, 2, 0, 4};   // mid-phase change
    vecs[13] = '{7, 5, 1, 0, 1, 0, 4};
    vecs[14] = '{7, 5, 1, 1, 5, 1, 5};
    vecs[15] = '{7, 5, 5, 0, 7, 0, 5};

    emu_rst = 1'b1;
    t_lo = 0; t_hi = 0; emu_dt = 0;
    repeat (2) @(posedge emu_clk);
    #1;
    chk("rst_dt_req", dt_req, ALL1);
    chk("rst_clk_val", clk_val, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_cke", cke, 0);
    emu_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].lo, vecs[i].hi, vecs[i].dt);
      chk($sformatf("vec%0d_cke", i), cke, vecs[i].e_cke);
      tick();
      chk($sformatf("vec%0d_dt_req", i), dt_req, vecs[i].e_dt_req);
      chk($sformatf("vec%0d_clk_val", i), clk_val, vecs[i].e_clk);
      chk($sformatf("vec%0d_edge_cnt", i), edge_cnt, vecs[i].e_edges);
      chk($sformatf("vec%0d_err", i), err, 0);
    end

    // Reset mid-phase with rem=2 and edge_cnt=5, asserted between clock edges.
    apply(7, 5, 5);
    tick();
    chk("pre_rst_dt_req", dt_req, 2);
    chk("pre_rst_edge_cnt", edge_cnt, 5);
    #2;
    emu_rst = 1'b1;
    #1;
    chk("async_rst_dt_req", dt_req, ALL1);
    chk("async_rst_clk_val", clk_val, 0);
    chk("async_rst_edge_cnt", edge_cnt, 0);
    chk("async_rst_err", err, 0);
    tick();
    emu_rst = 1'b0;
    apply(3, 5, 0);
    chk("load_cycle_dt_req", dt_req, ALL1);
    tick();
    chk("after_load_dt_req", dt_req, 3);

    // Overshoot: emu_dt=4 against rem=3.
    apply(3, 5, 4);
    chk("ovr_cke", cke, ERR_EN ? 0 : 1);
    tick();
    chk("ovr_err", err, ERR_EN ? 1 : 0);
    chk("ovr_clk_val", clk_val, ERR_EN ? 0 : 1);
    chk("ovr_dt_req", dt_req, ERR_EN ? 3 : 5);
    chk("ovr_edge_cnt", edge_cnt, ERR_EN ? 0 : 1);

    // Randomized run against the reference model.
    emu_rst = 1'b1;
    tick();
    emu_rst = 1'b0;
    m_reset();
    for (int k = 0; k < 400; k++) begin
      lo = $urandom_range(0, 6);
      hi = $urandom_range(0, 6);
      if (!m_loaded) begin
        dt = $urandom;
      end else begin
        r   = m_remaining();
        sel = $urandom_range(0, 9);
        if (sel < 5)       dt = $urandom_range(0, r);
        else if (sel < 8)  dt = r;
        else if (sel == 8) dt = r + $urandom_range(1, 3);
        else               dt = 0;
      end
      apply(lo, hi, dt);
      chk("rnd_cke", cke, m_cke(dt));
      chk("rnd_dt_req_pre", dt_req, m_dt_req());
      tick();
      m_step(lo, hi, dt);
      chk("rnd_dt_req", dt_req, m_dt_req());
      chk("rnd_clk_val", clk_val, m_level);
      chk("rnd_edge_cnt", edge_cnt, m_edges);
      chk("rnd_err", err, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
